multiplier_v3: RTL

Parametrised, fully pipelined integer multiplier; the next generation after the fixed 32-bit three-stage stall-driven multiplier. It sits in the execute/mul path of the CPU pipeline.
- Adds a valid/ready elastic handshake in place of external stall bits, a flush input, and RISC/LoongArch-style result-select modes.
- Makes operand width and pipeline depth compile-time parameters.

---
 rtl/multiplier_v3.sv | 112 +++++++++++
 1 files changed

// File: rtl/multiplier_v3.sv
// Elastic, flushable integer multiplier with STAGES register slices and RISC-style result select.
// Optional tag pipeline enabled by defining MULTIPLIER_V3_ID_EN.
module multiplier_v3 #(
  parameter int WIDTH    = 32,
  parameter int STAGES   = 3,
  parameter int ID_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [1:0]          op_i,
  input  logic [WIDTH-1:0]    X_i,
  input  logic [WIDTH-1:0]    Y_i,
`ifdef MULTIPLIER_V3_ID_EN
  input  logic [ID_WIDTH-1:0] in_id_i,
  output logic [ID_WIDTH-1:0] out_id_o,
`endif
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [WIDTH-1:0]    res_o
);

  if (WIDTH < 8 || WIDTH > 64 || (WIDTH % 2) != 0 || STAGES < 1 || STAGES > 4 || ID_WIDTH < 1)
  begin : g_bad_param
    $error("multiplier_v3: unsupported parameter combination");
  end

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] v_in;
  logic [WIDTH-1:0]  res_q [STAGES];
  logic [WIDTH-1:0]  r_in  [STAGES];
`ifdef MULTIPLIER_V3_ID_EN
  logic [ID_WIDTH-1:0] id_q  [STAGES];
  logic [ID_WIDTH-1:0] id_in [STAGES];
`endif

  // Extending both operands to 2*WIDTH makes the modular product bit-exact for every mode.
  logic               x_sx;
  logic               y_sx;
  logic [2*WIDTH-1:0] x_ext;
  logic [2*WIDTH-1:0] y_ext;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_sel;

  assign x_sx    = op_i[0] & X_i[WIDTH-1];
  assign y_sx    = (op_i == 2'b01) & Y_i[WIDTH-1];
  assign x_ext   = {{WIDTH{x_sx}}, X_i};
  assign y_ext   = {{WIDTH{y_sx}}, Y_i};
  assign prod    = x_ext * y_ext;
  assign res_sel = (op_i == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];

  // A stage moves when any stage at or after it is empty, or the consumer takes the head.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    assign adv[k] = out_ready_i | ~(&valid_q[STAGES-1:k]);
    if (k == 0) begin : g_head
      assign v_in[k] = in_valid_i;
      assign r_in[k] = res_sel;
`ifdef MULTIPLIER_V3_ID_EN
      assign id_in[k] = in_id_i;
`endif
    end else begin : g_body
      assign v_in[k] = valid_q[k-1];
      assign r_in[k] = res_q[k-1];
`ifdef MULTIPLIER_V3_ID_EN
      assign id_in[k] = id_q[k-1];
`endif
    end
  end

  always_comb begin
    valid_d = valid_q;
    for (int k = 0; k < STAGES; k++) begin
      if (adv[k]) valid_d[k] = v_in[k];
    end
    if (flush_i) valid_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        res_q[k] <= '0;
`ifdef MULTIPLIER_V3_ID_EN
        id_q[k]  <= '0;
`endif
      end
    end else begin
      valid_q <= valid_d;
      // Payload only loads when a valid op actually moves in.
      for (int k = 0; k < STAGES; k++) begin
        if (adv[k] && v_in[k]) begin
          res_q[k] <= r_in[k];
`ifdef MULTIPLIER_V3_ID_EN
          id_q[k]  <= id_in[k];
`endif
        end
      end
    end
  end

  assign in_ready_o  = adv[0] | flush_i;
  assign out_valid_o = valid_q[STAGES-1];
  assign res_o       = res_q[STAGES-1];
`ifdef MULTIPLIER_V3_ID_EN
  assign out_id_o    = id_q[STAGES-1];
`endif

endmodule
